brick_field: RTL
================

# brick_field

Brick-field manager for the Arkanoid game core, sitting directly downstream of the ball state controller. On each ball step it scans the brick grid for the first live brick overlapping the ball's bounding box, damages or clears it, and reports which velocity component(s) the ball controller must reflect. It also keeps the remaining-brick count and score, and gives the VGA renderer a combinational read port into brick health.

## Interface
- MAXROW, 8, brick rows
- MAXCOL, 10, brick columns
- BLK_W, 64, brick width in pixels
- BLK_H, 16, brick height in pixels
- TOP, 32, y pixel of the top edge of row 0 (column 0 starts at x=0)
- INIT_HP, 1, health loaded into every brick; range 1..15

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- enable  in  1  global advance qualifier; when low, all state holds
- load  in  1  refill field
- start_scan  in  1  pulse: sample ball and begin scan
- ball_x, ball_y  in  10 each  ball centre
- ball_radius  in  6  ball radius
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse at scan end
- hit  out  1  valid with done: a brick was struck
- flip_x, flip_y  out  1 each  valid with done: reflection request
- blocks_left  out  8  live bricks
- score  out  16  saturating score
- field_clear  out  1  blocks_left == 0
- rd_row  in  4  renderer read row
- rd_col  in  4  renderer read column
- rd_hp  out  4  health at (rd_row, rd_col); 0 if the address is out of range

## Operation
- State register hp[r][c]; a brick is live when hp != 0.
- FSM states: IDLE, SCAN, HIT, DONE. Transitions happen only while enable=1.
  - IDLE to SCAN on start_scan. Latch ball_x, ball_y and ball_radius, and clear the cursor to (0,0).
  - In SCAN, visit one cell per cycle in row-major order. Overlap test is inclusive: [bx-r, bx+r] intersects [c*BLK_W, c*BLK_W+BLK_W-1], and the same in y with the TOP offset.
  - The first live overlapping cell goes to HIT. Finishing the last cell with no match goes to DONE with hit=0.
  - HIT: decrement hp and add 1 to score. If hp becomes 0, add a further 9 to score and decrement blocks_left. Then go to DONE.
  - DONE: pulse done for one cycle, then go to IDLE.
- Reflection side, computed from the latched centre against the struck brick:
  - centre x inside the brick's x span: flip_y=1.
  - otherwise, centre y inside the brick's y span: flip_x=1.
  - otherwise (corner): both flags set.
  - Both flags are 0 when hit=0.
- Arithmetic uses 11-bit signed values so that bx-r below 0 is handled correctly. Score saturates at 0xFFFF.
- At most one brick is struck per scan.
- start_scan is ignored while busy.
- load has priority over everything. In one cycle it sets all hp=INIT_HP, blocks_left=MAXROW*MAXCOL, score=0, FSM to IDLE. A scan in progress is aborted with no done pulse.
- load and start_scan asserted together: load wins, start_scan is dropped.
- enable=0 freezes the FSM, cursor and counters. A done pulse is stretched until enable returns.

## Timing
- Reset values: FSM=IDLE, every hp=INIT_HP, blocks_left=MAXROW*MAXCOL, score=0. busy, done, hit, flip_x and flip_y are 0; field_clear=0.
- busy is high from the cycle after the accepted start_scan until the cycle done is high, inclusive.
- Latency from start_scan to done:
  - hit on cell index k: k+3 cycles.
  - miss: MAXROW*MAXCOL+2 cycles.
- hit, flip_x and flip_y are registered and valid only while done=1.
- blocks_left, score and field_clear update on the clock edge that leaves HIT.
- rd_hp is combinational from rd_row/rd_col and current hp. It reflects an update the cycle after the write.

## Configuration
- BRICK_HP_EN defined: 4-bit hp per brick; INIT_HP is honoured; multi-hit bricks score +1 per hit.
- BRICK_HP_EN undefined:
  - 1-bit storage per brick; INIT_HP is treated as 1.
  - Every hit destroys the brick (+10 score).
  - rd_hp returns 0 or 1.

## Structure
- Shared package holds the FSM state enum, the geometry constants (BLK_W, BLK_H, TOP, MAXX=639, MAXY=479) and the score increments. The ball controller and renderer use the same package.
- One sub-module, brick_overlap: purely combinational. It takes latched ball, row and column, and returns overlap, flip_x and flip_y.

## Test plan
- Reset, then rd_row=0/rd_col=0: rd_hp=1, blocks_left=80, score=0, field_clear=0.
- Ball (96,40) r=4, start_scan: done at cycle 4 (cell 1) with hit=1, flip_y=1. rd_hp(0,1)=0, blocks_left=79, score=10.
- Ball (64,40) r=4 (edge between col 0 and 1): col 0 wins, flip_x=1; only one brick is cleared.
- Ball (320,300) r=4: no overlap, done after 82 cycles with hit=0 and flip flags 0; counters unchanged.
- Mid-scan load: busy drops next cycle, no done pulse; all bricks are restored and score=0.
- BRICK_HP_EN with INIT_HP=2: first hit gives score=1 and rd_hp=1. The second hit gives score=11 and blocks_left=79.

Source files
------------

// File: rtl/brick_field_pkg.sv
// Shared Arkanoid brick-field definitions: FSM states, playfield geometry and score increments.
package brick_field_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_HIT,
        ST_DONE
    } state_t;

    localparam int unsigned BLK_W = 64;
    localparam int unsigned BLK_H = 16;
    localparam int unsigned TOP   = 32;
    localparam int unsigned MAXX  = 639;
    localparam int unsigned MAXY  = 479;

    // Signed coordinate width: leaves headroom for ball extents left of / above the screen.
    localparam int unsigned CW = 11;

    localparam int unsigned SCORE_HIT   = 1;
    localparam int unsigned SCORE_CLEAR = 9;

endpackage

// File: rtl/brick_overlap.sv
// Inclusive bounding-box overlap of the latched ball against one brick, plus reflection side.
module brick_overlap
    import brick_field_pkg::*;
(
    input  logic [9:0] bx,
    input  logic [9:0] by,
    input  logic [5:0] br,
    input  logic [3:0] row,
    input  logic [3:0] col,
    output logic       overlap,
    output logic       flip_x,
    output logic       flip_y
);

    logic signed [CW-1:0] cx, cy, rr;
    logic signed [CW-1:0] x_lo, x_hi, y_lo, y_hi;
    logic signed [CW-1:0] b_l, b_r, b_t, b_b;
    logic                 in_x, in_y;

    always_comb begin
        cx   = CW'(bx);
        cy   = CW'(by);
        rr   = CW'(br);
        x_lo = CW'(32'(col) * BLK_W);
        x_hi = x_lo + CW'(BLK_W - 1);
        y_lo = CW'(TOP + 32'(row) * BLK_H);
        y_hi = y_lo + CW'(BLK_H - 1);
        b_l  = cx - rr;
        b_r  = cx + rr;
        b_t  = cy - rr;
        b_b  = cy + rr;

        overlap = (b_l <= x_hi) && (b_r >= x_lo) && (b_t <= y_hi) && (b_b >= y_lo);
        in_x    = (cx >= x_lo) && (cx <= x_hi);
        in_y    = (cy >= y_lo) && (cy <= y_hi);
        // Centre over the brick face bounces vertically; beside it horizontally; else a corner.
        flip_y  = in_x || !in_y;
        flip_x  = !in_x;
    end

endmodule

// File: rtl/brick_field.sv
// Brick-field manager: scans the grid per ball step, damages the first struck brick, tracks score.
// Build option: BRICK_HP_EN selects 4-bit multi-hit bricks; otherwise 1-bit single-hit bricks.
module brick_field
    import brick_field_pkg::*;
#(
    parameter int unsigned MAXROW  = 8,
    parameter int unsigned MAXCOL  = 10,
    parameter int unsigned INIT_HP = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        load,
    input  logic        start_scan,
    input  logic [9:0]  ball_x,
    input  logic [9:0]  ball_y,
    input  logic [5:0]  ball_radius,
    output logic        busy,
    output logic        done,
    output logic        hit,
    output logic        flip_x,
    output logic        flip_y,
    output logic [7:0]  blocks_left,
    output logic [15:0] score,
    output logic        field_clear,
    input  logic [3:0]  rd_row,
    input  logic [3:0]  rd_col,
    output logic [3:0]  rd_hp
);

`ifdef BRICK_HP_EN
    localparam int unsigned HPW = 4;
    localparam logic [HPW-1:0] HP_FILL = HPW'(INIT_HP);
`else
    localparam int unsigned HPW = 1;
    localparam logic [HPW-1:0] HP_FILL = 1'b1;
`endif
    localparam int unsigned NCELL  = MAXROW * MAXCOL;
    localparam int unsigned IW     = $clog2(NCELL);
    localparam logic [7:0]  NBRICK = 8'(NCELL);

    state_t          state, state_n;
    logic [3:0]      cur_row, cur_col, row_n, col_n;
    logic [9:0]      lat_x, lat_y;
    logic [5:0]      lat_r;
    logic [HPW-1:0]  hp [NCELL];
    logic [IW-1:0]   cur_idx, rd_idx;
    logic [HPW-1:0]  hp_cur, hp_dec;
    logic            in_grid, cell_live, clr, rd_ok;
    logic            ov_hit, ov_fx, ov_fy;
    logic [16:0]     sc_sum;
    logic [15:0]     score_n;
    logic [7:0]      blocks_n;

    brick_overlap u_overlap (
        .bx      (lat_x),
        .by      (lat_y),
        .br      (lat_r),
        .row     (cur_row),
        .col     (cur_col),
        .overlap (ov_hit),
        .flip_x  (ov_fx),
        .flip_y  (ov_fy)
    );

    // Cursor cell and the damage/score update it would cause if struck.
    always_comb begin
        in_grid   = 32'(cur_row) < MAXROW;
        cur_idx   = IW'(32'(cur_row) * MAXCOL + 32'(cur_col));
        hp_cur    = hp[cur_idx];
        cell_live = in_grid && (hp_cur != '0);
        hp_dec    = hp_cur - HPW'(1);
        clr       = (hp_dec == '0);
        sc_sum    = 17'(score) + 17'(clr ? SCORE_HIT + SCORE_CLEAR : SCORE_HIT);
        score_n   = sc_sum[16] ? 16'hFFFF : sc_sum[15:0];
        blocks_n  = clr ? blocks_left - 8'd1 : blocks_left;
    end

    // Renderer read port, zero outside the grid.
    always_comb begin
        rd_ok  = (32'(rd_row) < MAXROW) && (32'(rd_col) < MAXCOL);
        rd_idx = IW'(32'(rd_row) * MAXCOL + 32'(rd_col));
        rd_hp  = rd_ok ? 4'(hp[rd_idx]) : 4'd0;
    end

    always_comb begin
        state_n = state;
        row_n   = cur_row;
        col_n   = cur_col;
        unique case (state)
            ST_IDLE: begin
                if (start_scan) begin
                    state_n = ST_SCAN;
                    row_n   = '0;
                    col_n   = '0;
                end
            end
            ST_SCAN: begin
                // Cursor walks one cell past the grid before declaring a miss.
                if (!in_grid) begin
                    state_n = ST_DONE;
                end else if (cell_live && ov_hit) begin
                    state_n = ST_HIT;
                end else if (cur_col == 4'(MAXCOL - 1)) begin
                    col_n = '0;
                    row_n = cur_row + 4'd1;
                end else begin
                    col_n = cur_col + 4'd1;
                end
            end
            ST_HIT:  state_n = ST_DONE;
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NCELL; i++) hp[i] <= HP_FILL;
        end else if (load) begin
            for (int unsigned i = 0; i < NCELL; i++) hp[i] <= HP_FILL;
        end else if (enable && state == ST_HIT) begin
            hp[cur_idx] <= hp_dec;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cur_row     <= '0;
            cur_col     <= '0;
            lat_x       <= '0;
            lat_y       <= '0;
            lat_r       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hit         <= 1'b0;
            flip_x      <= 1'b0;
            flip_y      <= 1'b0;
            score       <= '0;
            blocks_left <= NBRICK;
            field_clear <= 1'b0;
        end else if (load) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            hit         <= 1'b0;
            flip_x      <= 1'b0;
            flip_y      <= 1'b0;
            score       <= '0;
            blocks_left <= NBRICK;
            field_clear <= 1'b0;
        end else if (enable) begin
            state   <= state_n;
            cur_row <= row_n;
            cur_col <= col_n;
            if (state == ST_IDLE && start_scan) begin
                lat_x <= ball_x;
                lat_y <= ball_y;
                lat_r <= ball_radius;
            end
            busy   <= (state_n != ST_IDLE);
            done   <= (state_n == ST_DONE);
            hit    <= (state == ST_HIT);
            flip_x <= (state == ST_HIT) && ov_fx;
            flip_y <= (state == ST_HIT) && ov_fy;
            if (state == ST_HIT) begin
                score       <= score_n;
                blocks_left <= blocks_n;
                field_clear <= (blocks_n == '0);
            end
        end
    end

endmodule
